// File: rtl/xdom_pkg.sv
// Shared definitions for the cross-domain pulse sender: channel FSM
// encodings and the pending-count width helper.
package xdom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } chan_state_t;

  // Width of a counter that holds 0..depth, never narrower than one bit.
  function automatic int pend_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < (depth + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/mch_pulse_sender_chan.sv
// One pulse channel: ack synchroniser, four-phase request FSM, pending
// pulse counter and sticky overflow flag.
module mch_pulse_sender_chan
  import xdom_pkg::*;
#(
  parameter  int DEPTH       = 3,
  parameter  int SYNC_STAGES = 2,
  localparam int PW          = pend_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse,
  input  logic          err_clr,
  input  logic          ack,
  output logic          req,
  output logic          busy,
  output logic          err,
  output logic [PW-1:0] pend
);

  localparam logic [PW-1:0] PEND_MAX = PW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  chan_state_t            state;
  chan_state_t            state_nxt;
  logic [PW-1:0]          pend_nxt;
  logic                   take;
  logic                   use_pend;
  logic                   queue_pulse;
  logic                   overflow;

  // Shift the far-side acknowledge through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Next-state, queue bookkeeping and overflow decode.
  // A transition into REQ consumes one queued pulse if any exist; otherwise
  // it consumes this cycle's pulse. A pulse arriving while a queued one is
  // consumed simply takes its slot, so it can never overflow.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pulse || (pend != '0)) && !ack_s) begin
          state_nxt = ST_REQ;
          take      = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack_s) state_nxt = ST_REL;
      end
      ST_REL: begin
        if (!ack_s) begin
          if (pulse || (pend != '0)) begin
            state_nxt = ST_REQ;
            take      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    use_pend    = take && (pend != '0);
    queue_pulse = pulse && !(take && (pend == '0));
    overflow    = queue_pulse && !use_pend && (pend == PEND_MAX);

    pend_nxt = pend;
    if (queue_pulse && !use_pend && !overflow) pend_nxt = pend + 1'b1;
    else if (use_pend && !queue_pulse)         pend_nxt = pend - 1'b1;
  end

  // Channel FSM with registered request, busy, pending count and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == ST_REQ);
      busy  <= (state_nxt != ST_IDLE) || (pend_nxt != '0);
      err   <= (err & ~err_clr) | overflow;
      pend  <= pend_nxt;
    end
  end

endmodule

// File: rtl/mch_pulse_sender.sv
// Multi-channel pulse sender: NCH independent four-phase handshake channels
// carrying single-cycle pulses towards a far clock domain.
module mch_pulse_sender
  import xdom_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int DEPTH       = 3,
  parameter  int SYNC_STAGES = 2,
  localparam int PW          = pend_width(DEPTH)
) (
  input  logic              odom_clk_i,
  input  logic              grst_i,
  input  logic [NCH-1:0]    odom_pulse_i,
  input  logic [NCH-1:0]    err_clr_i,
  output logic [NCH-1:0]    xdom_req_o,
  input  logic [NCH-1:0]    xdom_ack_i,
  output logic [NCH-1:0]    busy_o,
  output logic [NCH-1:0]    err_o,
  output logic [NCH*PW-1:0] pend_o
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    mch_pulse_sender_chan #(
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk    (odom_clk_i),
      .rst    (grst_i),
      .pulse  (odom_pulse_i[c]),
      .err_clr(err_clr_i[c]),
      .ack    (xdom_ack_i[c]),
      .req    (xdom_req_o[c]),
      .busy   (busy_o[c]),
      .err    (err_o[c]),
      .pend   (pend_o[c*PW +: PW])
    );
  end

endmodule

// File: tb/tb_mch_pulse_sender.sv
// Directed bench: a default-configured sender (4 channels, depth 3) and a
// single-channel depth-0 sender sharing clock and reset.
module tb_mch_pulse_sender;

  logic       clk = 1'b0;
  logic       rst;

  logic [3:0] pulse_a, clr_a, ack_a, req_a, busy_a, err_a;
  logic [7:0] pend_a;

  logic [0:0] pulse_b, clr_b, ack_b, req_b, busy_b, err_b, pend_b;

  int checks = 0;
  int errors = 0;

  int         rise_a [4] = '{0, 0, 0, 0};
  int         rise_b     = 0;
  logic [3:0] prev_a     = '0;
  logic       prev_b     = 1'b0;
  int         base;

  always #5 clk = ~clk;

  mch_pulse_sender #(.NCH(4), .DEPTH(3), .SYNC_STAGES(2)) dut_a (
    .odom_clk_i  (clk),
    .grst_i      (rst),
    .odom_pulse_i(pulse_a),
    .err_clr_i   (clr_a),
    .xdom_req_o  (req_a),
    .xdom_ack_i  (ack_a),
    .busy_o      (busy_a),
    .err_o       (err_a),
    .pend_o      (pend_a)
  );

  mch_pulse_sender #(.NCH(1), .DEPTH(0), .SYNC_STAGES(2)) dut_b (
    .odom_clk_i  (clk),
    .grst_i      (rst),
    .odom_pulse_i(pulse_b),
    .err_clr_i   (clr_b),
    .xdom_req_o  (req_b),
    .xdom_ack_i  (ack_b),
    .busy_o      (busy_b),
    .err_o       (err_b),
    .pend_o      (pend_b)
  );

  // Count rising edges of each request, sampled shortly after every clock edge.
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < 4; c++) if (req_a[c] && !prev_a[c]) rise_a[c]++;
    prev_a = req_a;
    if (req_b[0] && !prev_b) rise_b++;
    prev_b = req_b[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int c, input logic lvl, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_a[c] === lvl) break;
    end
    chk(tag, req_a[c], lvl);
  endtask

  task automatic wait_idle(input int c, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a[c] === 1'b0) break;
    end
    chk(tag, busy_a[c], 0);
  endtask

  task automatic handshake(input int c);
    wait_req(c, 1'b1, "hs_req_high");
    ack_a[c] = 1'b1;
    wait_req(c, 1'b0, "hs_req_low");
    ack_a[c] = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    pulse_a = '0; clr_a = '0; ack_a = '0;
    pulse_b = '0; clr_b = '0; ack_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_a",  req_a,  0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_err_a",  err_a,  0);
    chk("rst_pend_a", pend_a, 0);
    chk("rst_req_b",  req_b,  0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single pulse on ch0, ack returned three cycles after req rises
    base = rise_a[0];
    pulse_a[0] = 1'b1;
    @(negedge clk); pulse_a[0] = 1'b0;
    chk("c0_req_rise", req_a[0], 1);
    chk("c0_busy", busy_a[0], 1);
    repeat (2) @(negedge clk);
    ack_a[0] = 1'b1;
    @(negedge clk); chk("c0_req_hold1", req_a[0], 1);
    @(negedge clk); chk("c0_req_hold2", req_a[0], 1);
    @(negedge clk); chk("c0_req_fall", req_a[0], 0);
    chk("c0_busy_rel", busy_a[0], 1);
    ack_a[0] = 1'b0;
    @(negedge clk); chk("c0_busy_w1", busy_a[0], 1);
    @(negedge clk); chk("c0_busy_w2", busy_a[0], 1);
    @(negedge clk); chk("c0_busy_done", busy_a[0], 0);
    chk("c0_one_edge", rise_a[0] - base, 1);

    // Five back-to-back pulses on ch1: three queue, one overflows
    base = rise_a[1];
    pulse_a[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("c1_pend_full", pend_a[3:2], 3);
    chk("c1_err_not_yet", err_a[1], 0);
    @(negedge clk); pulse_a[1] = 1'b0;
    chk("c1_pend_sat", pend_a[3:2], 3);
    chk("c1_err_set", err_a[1], 1);
    repeat (4) handshake(1);
    wait_idle(1, "c1_idle");
    chk("c1_pend_drained", pend_a[3:2], 0);
    chk("c1_four_reqs", rise_a[1] - base, 4);
    chk("c1_err_sticky", err_a[1], 1);
    clr_a[1] = 1'b1;
    @(negedge clk); clr_a[1] = 1'b0;
    chk("c1_err_clr", err_a[1], 0);

    // Pulse coinciding with a REL->REQ transition that consumes a queued pulse
    base = rise_a[1];
    pulse_a[1] = 1'b1;
    repeat (3) @(negedge clk);
    pulse_a[1] = 1'b0;
    chk("c1b_pend2", pend_a[3:2], 2);
    ack_a[1] = 1'b1;
    wait_req(1, 1'b0, "c1b_rel");
    ack_a[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("c1b_pend_pre", pend_a[3:2], 2);
    chk("c1b_req_pre", req_a[1], 0);
    pulse_a[1] = 1'b1;
    @(negedge clk); pulse_a[1] = 1'b0;
    chk("c1b_rel_to_req", req_a[1], 1);
    chk("c1b_pend_kept", pend_a[3:2], 2);
    chk("c1b_no_err", err_a[1], 0);
    repeat (3) handshake(1);
    wait_idle(1, "c1b_idle");
    chk("c1b_four_reqs", rise_a[1] - base, 4);
    chk("c1b_err_clean", err_a[1], 0);

    // Depth-0 sender: pulse during handshake is dropped and flagged
    base = rise_b;
    pulse_b = 1'b1;
    @(negedge clk);
    chk("b_req", req_b, 1);
    @(negedge clk); pulse_b = 1'b0;
    chk("b_err_drop", err_b, 1);
    chk("b_pend_zero", pend_b, 0);
    clr_b = 1'b1;
    @(negedge clk); clr_b = 1'b0;
    chk("b_err_clr", err_b, 0);
    pulse_b = 1'b1; clr_b = 1'b1;
    @(negedge clk); pulse_b = 1'b0; clr_b = 1'b0;
    chk("b_set_wins", err_b, 1);
    clr_b = 1'b1;
    @(negedge clk); clr_b = 1'b0;
    chk("b_err_clr2", err_b, 0);
    ack_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_b[0] === 1'b0) break;
    end
    chk("b_req_fall", req_b, 0);
    ack_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_b[0] === 1'b0) break;
    end
    chk("b_idle", busy_b, 0);
    chk("b_one_req", rise_b - base, 1);

    // Reset mid-handshake on ch3 with two pulses queued
    pulse_a[3] = 1'b1;
    repeat (3) @(negedge clk);
    pulse_a[3] = 1'b0;
    chk("c3_req", req_a[3], 1);
    chk("c3_pend2", pend_a[7:6], 2);
    ack_a[2] = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_async_req",  req_a,  0);
    chk("rst_async_busy", busy_a, 0);
    chk("rst_async_err",  err_a,  0);
    chk("rst_async_pend", pend_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Stale ack on ch2 from reset release; pulse at cycle 5 must wait
    repeat (4) @(negedge clk);
    pulse_a[2] = 1'b1;
    @(negedge clk); pulse_a[2] = 1'b0;
    chk("c2_no_req", req_a[2], 0);
    chk("c2_pend1", pend_a[5:4], 1);
    chk("c2_busy", busy_a[2], 1);
    repeat (3) @(negedge clk);
    chk("c2_still_no_req", req_a[2], 0);
    ack_a[2] = 1'b0;
    @(negedge clk); chk("c2_wait1", req_a[2], 0);
    @(negedge clk); chk("c2_wait2", req_a[2], 0);
    chk("c2_pend_wait", pend_a[5:4], 1);
    @(negedge clk); chk("c2_req_go", req_a[2], 1);
    chk("c2_pend_used", pend_a[5:4], 0);
    ack_a[2] = 1'b1;
    wait_req(2, 1'b0, "c2_req_fall");
    ack_a[2] = 1'b0;
    wait_idle(2, "c2_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mch_pulse_sender.md
MCH_PULSE_SENDER -- requirements
Module: mch_pulse_sender

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent pulse channels (1..32).
REQ-002 SHALL have parameter DEPTH, default 3: pending pulses queued per channel while busy (0..15); 0 gives drop-and-flag behaviour.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: ack synchroniser flops (2..4).
REQ-004 SHALL have port odom_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port grst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port odom_pulse_i  in  NCH  single-cycle pulse requests, one bit per channel.
REQ-007 SHALL have port err_clr_i  in  NCH  single-cycle clear of the sticky error, per channel.
REQ-008 SHALL have port xdom_req_o  in... out  NCH  registered level request towards the far clock domain.
REQ-009 SHALL have port xdom_ack_i  in  NCH  asynchronous level acknowledge from the far domain.
REQ-010 SHALL have port busy_o  out  NCH  channel handshake active or pulses pending.
REQ-011 SHALL have port err_o  out  NCH  sticky overflow flag.
REQ-012 SHALL have port pend_o  out  NCH*PW  pending count per channel, PW = max(1, clog2(DEPTH+1)), channel c at bits [c*PW +: PW].

Function
REQ-013 Each channel SHALL pass xdom_ack_i[c] through SYNC_STAGES flops to give ack_s[c]; no other logic uses xdom_ack_i.
REQ-014 Each channel SHALL run a four-phase FSM: IDLE, REQ, REL.
REQ-015 IDLE -> REQ when (pulse or pend>0) and ack_s=0; xdom_req_o rises on the edge after the accepting cycle (latency 1).
REQ-016 REQ: xdom_req_o=1; -> REL when ack_s=1.
REQ-017 REL: xdom_req_o=0; -> IDLE when ack_s=0 and pend=0; -> REQ directly when ack_s=0 and pend>0 (or pulse that cycle).
REQ-018 An IDLE->REQ or REL->REQ transition driven by pend>0 SHALL decrement pend by 1; one driven by a same-cycle pulse with pend=0 SHALL not change pend.
REQ-019 A pulse not consumed by a transition that cycle SHALL increment pend if pend<DEPTH; otherwise pend holds and err_o sets.
REQ-020 Pulse and consumption in the same cycle with pend>0 SHALL leave pend unchanged and never set err_o.
REQ-021 IDLE with ack_s=1 (stale far-side ack) SHALL not start a request; pulses queue per REQ-019.
REQ-022 err_o SHALL be sticky; err_clr_i clears it; simultaneous set and clear SHALL leave err_o=1.
REQ-023 busy_o SHALL equal (state!=IDLE) or (pend!=0), derived from registers only.
REQ-024 Channels SHALL be fully independent; no arbitration or shared state.
REQ-025 With DEPTH=0, any pulse while busy_o=1 SHALL be dropped and set err_o.

Reset
REQ-026 grst_i SHALL asynchronously force: state IDLE, xdom_req_o=0, pend=0, err_o=0, busy_o=0, synchroniser flops 0.
REQ-027 Reset mid-handshake SHALL drop xdom_req_o immediately; after release a new request SHALL wait for ack_s=0 per REQ-021.

Structure
REQ-028 Shared package xdom_pkg SHALL hold the FSM state encodings (IDLE=0, REQ=1, REL=2) and the PW width function.
REQ-029 One sub-module, mch_pulse_sender_chan (synchroniser, FSM, pend counter, err flag), SHALL be instantiated NCH times by a generate loop.

Verification
REQ-030 Single pulse ch0, ack returned 3 cycles after req -> req_o[0] rises 1 cycle after pulse, falls 1 cycle after ack_s high, busy_o[0] low after ack_s low; exactly one req edge.
REQ-031 DEPTH=3: 5 back-to-back pulses on ch1 during handshake -> pend_o reaches 3, err_o[1]=1, exactly 4 req cycles total (first handshake + 3 queued).
REQ-032 Pulse on same cycle REL->REQ consumes pend=2 -> pend stays 2, err_o=0.
REQ-033 xdom_ack_i[2] held high from reset release, pulse at cycle 5 -> no req until ack low + SYNC_STAGES cycles; pend_o=1 meanwhile.
REQ-034 grst_i asserted while req_o[3]=1 and pend=2 -> all outputs 0 within the reset time, no clock needed.
REQ-035 DEPTH=0, NCH=1: second pulse during handshake -> dropped, err_o=1; err_clr_i -> err_o=0 next cycle.
